dcache_2way_top: RTL and testbench

//  Parametrised 2-way set-associative, write-back, write-allocate data cache between the CPU
//  p1 port and line-wide data memory. Next generation of the direct-mapped dcache: adds
//  set depth, line width and word width parameters, true-LRU replacement per set, and in-block
//  tag, valid, dirty and data arrays. Sits between the pipeline MEM stage and data memory.

---
 rtl/dcache_2way_top_if.sv | 30 +++
 rtl/dcache_2way_top.sv | 157 +++++++++++++++
 tb/tb_dcache_2way_top.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dcache_2way_top_if.sv
// CPU p1 port and line-wide data memory port of the 2-way data cache.
// The cache attaches through the slave modport; the CPU/memory side uses master.
interface dcache_2way_top_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LINE_W = 256
);
    logic [WORD_W-1:0] p1_data_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic              p1_MemRead_i;
    logic              p1_MemWrite_i;
    logic [WORD_W-1:0] p1_data_o;
    logic              p1_stall_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_enable_o;
    logic              mem_write_o;

    modport slave (
        input  p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
        output p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
    );

    modport master (
        output p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
        input  p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
    );
endinterface

// File: rtl/dcache_2way_top.sv
// 2-way set-associative, write-back, write-allocate data cache with true-LRU per set.
// Hits complete combinationally in IDLE; misses run write-back (if dirty) then refill.
module dcache_2way_top #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned SETS   = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    dcache_2way_top_if.slave  bus
);
    localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned BYTE_W = $clog2(WORD_W / 8);
    localparam int unsigned WSEL_W = OFF_W - BYTE_W;
    localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE, S_MISS, S_WRITEBACK, S_REFILL, S_REFILL_DONE
    } state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]  tag_q   [2][SETS];
    logic [LINE_W-1:0] data_q  [2][SETS];
    logic [SETS-1:0]   valid_q [2];
    logic [SETS-1:0]   dirty_q [2];
    logic [SETS-1:0]   lru_q;

    logic              vic_q;
    logic [TAG_W-1:0]  mtag_q;
    logic [IDX_W-1:0]  midx_q;

    logic [LINE_W-1:0] mem_data_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_enable_q;
    logic              mem_write_q;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_word;
    logic              req;
    logic [1:0]        hit_w;
    logic              hit;
    logic              hit_way;
    logic              victim;
    logic              vic_dirty;
    logic [LINE_W-1:0] hit_line;
    logic              unused_addr_bits;

    assign req_tag  = bus.p1_addr_i[ADDR_W-1:OFF_W+IDX_W];
    assign req_idx  = bus.p1_addr_i[OFF_W+IDX_W-1:OFF_W];
    assign req_word = bus.p1_addr_i[OFF_W-1:BYTE_W];
    assign unused_addr_bits = &{1'b0, bus.p1_addr_i[BYTE_W-1:0]};
    assign req      = bus.p1_MemRead_i | bus.p1_MemWrite_i;

    assign hit_w[0] = (state_q == S_IDLE) & valid_q[0][req_idx] & (tag_q[0][req_idx] == req_tag);
    assign hit_w[1] = (state_q == S_IDLE) & valid_q[1][req_idx] & (tag_q[1][req_idx] == req_tag);
    assign hit      = |hit_w;
    assign hit_way  = hit_w[1];
    assign hit_line = data_q[hit_way][req_idx];

    // Fill an invalid way first; only when both are valid does LRU pick the victim.
    assign victim    = !valid_q[0][req_idx] ? 1'b0 :
                       !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
    assign vic_dirty = valid_q[vic_q][midx_q] & dirty_q[vic_q][midx_q];

    assign bus.p1_data_o    = (req && hit) ? hit_line[req_word*WORD_W +: WORD_W] : '0;
    assign bus.p1_stall_o   = req & ~hit;
    assign bus.mem_data_o   = mem_data_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_enable_o = mem_enable_q;
    assign bus.mem_write_o  = mem_write_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:        if (req && !hit) state_d = S_MISS;
            S_MISS:        state_d = vic_dirty ? S_WRITEBACK : S_REFILL;
            S_WRITEBACK:   if (bus.mem_ack_i) state_d = S_REFILL;
            S_REFILL:      if (bus.mem_ack_i) state_d = S_REFILL_DONE;
            S_REFILL_DONE: state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            valid_q[0]   <= '0;
            valid_q[1]   <= '0;
            dirty_q[0]   <= '0;
            dirty_q[1]   <= '0;
            lru_q        <= '0;
            vic_q        <= 1'b0;
            mtag_q       <= '0;
            midx_q       <= '0;
            mem_data_q   <= '0;
            mem_addr_q   <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: begin
                    if (req && hit) begin
                        lru_q[req_idx] <= ~hit_way;
                        if (bus.p1_MemWrite_i) dirty_q[hit_way][req_idx] <= 1'b1;
                    end else if (req) begin
                        vic_q  <= victim;
                        mtag_q <= req_tag;
                        midx_q <= req_idx;
                    end
                end
                S_MISS: begin
                    mem_enable_q <= 1'b1;
                    if (vic_dirty) begin
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= {tag_q[vic_q][midx_q], midx_q, {OFF_W{1'b0}}};
                        mem_data_q  <= data_q[vic_q][midx_q];
                    end else begin
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= {mtag_q, midx_q, {OFF_W{1'b0}}};
                    end
                end
                S_WRITEBACK: begin
                    if (bus.mem_ack_i) begin
                        mem_write_q            <= 1'b0;
                        mem_addr_q             <= {mtag_q, midx_q, {OFF_W{1'b0}}};
                        dirty_q[vic_q][midx_q] <= 1'b0;
                    end
                end
                S_REFILL: begin
                    if (bus.mem_ack_i) begin
                        valid_q[vic_q][midx_q] <= 1'b1;
                        dirty_q[vic_q][midx_q] <= 1'b0;
                        mem_enable_q           <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data storage carry no reset; valid bits alone decide residency.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (req && hit && bus.p1_MemWrite_i)
                data_q[hit_way][req_idx][req_word*WORD_W +: WORD_W] <= bus.p1_data_i;
            if (state_q == S_REFILL && bus.mem_ack_i) begin
                data_q[vic_q][midx_q] <= bus.mem_data_i;
                tag_q[vic_q][midx_q]  <= mtag_q;
            end
        end
    end
endmodule

// File: tb/tb_dcache_2way_top.sv
// Scoreboard bench for dcache_2way_top: expected load data and memory transactions
// are queued when stimulus is issued and compared when the cache produces them.
module tb_dcache_2way_top;
    localparam int MEM_DELAY = 3;
    localparam int BUDGET    = 100;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic        has_word;
        logic [2:0]  widx;
        logic [31:0] word;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [31:0] exp_q [$];
    txn_t        exp_txn [$];
    logic [31:0] refm [logic [31:0]];
    logic [31:0] memm [logic [31:0]];

    dcache_2way_top_if #(.ADDR_W(32), .WORD_W(32), .LINE_W(256)) bus ();

    dcache_2way_top #(.ADDR_W(32), .WORD_W(32), .LINE_W(256), .SETS(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return memm.exists(a) ? memm[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : init_word(a);
    endfunction

    task automatic push_txn(input logic wr, input logic [31:0] addr, input logic has_word,
                            input logic [2:0] widx, input logic [31:0] word);
        txn_t t;
        t.wr = wr; t.addr = addr; t.has_word = has_word; t.widx = widx; t.word = word;
        exp_txn.push_back(t);
    endtask

    // One CPU access held until the stall drops; returns the number of stalled samples.
    task automatic cpu_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              output int stalls);
        @(negedge clk);
        bus.p1_addr_i     = addr;
        bus.p1_data_i     = wdata;
        bus.p1_MemRead_i  = !wr;
        bus.p1_MemWrite_i = wr;
        if (wr) refm[addr] = wdata;
        else    exp_q.push_back(ref_rd(addr));
        stalls = 0;
        #1;
        while (bus.p1_stall_o && stalls < BUDGET) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= BUDGET) begin
            chk("stall_timeout", 32'(stalls), 32'(BUDGET - 1));
            if (!wr) void'(exp_q.pop_front());
        end else if (!wr) begin
            chk("load_data", bus.p1_data_o, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        bus.p1_MemRead_i  = 1'b0;
        bus.p1_MemWrite_i = 1'b0;
    endtask

    initial begin : mem_model
        txn_t         t;
        logic [31:0]  a;
        logic         w;
        logic [255:0] line;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_ack_i) begin
                bus.mem_ack_i = 1'b0;
            end else if (bus.mem_enable_o && !rst) begin
                a = bus.mem_addr_o;
                w = bus.mem_write_o;
                if (exp_txn.size() == 0) begin
                    chk("txn_pending", 32'(exp_txn.size()), 32'd1);
                end else begin
                    t = exp_txn.pop_front();
                    chk("txn_write", 32'(w), 32'(t.wr));
                    chk("txn_addr", a, t.addr);
                    if (t.has_word) chk("wb_word", bus.mem_data_o[t.widx*32 +: 32], t.word);
                end
                if (w) begin
                    for (int i = 0; i < 8; i++) memm[a + 32'(i * 4)] = bus.mem_data_o[i*32 +: 32];
                end else begin
                    for (int i = 0; i < 8; i++) line[i*32 +: 32] = mem_rd(a + 32'(i * 4));
                    bus.mem_data_i = line;
                end
                repeat (MEM_DELAY - 1) @(negedge clk);
                bus.mem_ack_i = 1'b1;
            end
        end
    end

    initial begin : stim
        int s;
        int i;
        bus.p1_addr_i     = '0;
        bus.p1_data_i     = '0;
        bus.p1_MemRead_i  = 1'b0;
        bus.p1_MemWrite_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_enable", 32'(bus.mem_enable_o), 32'd0);
        chk("rst_write", 32'(bus.mem_write_o), 32'd0);
        chk("rst_stall", 32'(bus.p1_stall_o), 32'd0);

        // Cold load: refill 0x40, stall for 3 cycles plus the ack delay
        push_txn(1'b0, 32'h40, 1'b0, 3'd0, '0);
        cpu_access(1'b0, 32'h40, '0, s);
        chk("t1_stalls", 32'(s), 32'(3 + MEM_DELAY));

        // Store hit, then read it back
        cpu_access(1'b1, 32'h44, 32'h1234_5678, s);
        chk("t2_store_stalls", 32'(s), 32'd0);
        cpu_access(1'b0, 32'h44, '0, s);
        chk("t2_load_stalls", 32'(s), 32'd0);

        // Two tags in set 0 fill both ways; the repeat hits
        push_txn(1'b0, 32'h000, 1'b0, 3'd0, '0);
        cpu_access(1'b0, 32'h000, '0, s);
        push_txn(1'b0, 32'h200, 1'b0, 3'd0, '0);
        cpu_access(1'b0, 32'h200, '0, s);
        cpu_access(1'b0, 32'h000, '0, s);
        chk("t3_hit_stalls", 32'(s), 32'd0);

        // Third tag evicts the LRU way (0x200); 0x000 stays resident
        push_txn(1'b0, 32'h400, 1'b0, 3'd0, '0);
        cpu_access(1'b0, 32'h400, '0, s);
        chk("t4_miss_stalls", 32'(s), 32'(3 + MEM_DELAY));
        cpu_access(1'b0, 32'h000, '0, s);
        chk("t4_keep_stalls", 32'(s), 32'd0);

        // Dirty victim: store allocates 0x200 over 0x400, then 0x400 forces a write-back
        push_txn(1'b0, 32'h200, 1'b0, 3'd0, '0);
        cpu_access(1'b1, 32'h208, 32'hCAFE_F00D, s);
        cpu_access(1'b0, 32'h000, '0, s);
        chk("t5_way0_stalls", 32'(s), 32'd0);
        push_txn(1'b1, 32'h200, 1'b1, 3'd2, 32'hCAFE_F00D);
        push_txn(1'b0, 32'h400, 1'b0, 3'd0, '0);
        cpu_access(1'b0, 32'h404, '0, s);
        chk("t5_wb_stalls", 32'(s), 32'(4 + 2 * MEM_DELAY));
        push_txn(1'b0, 32'h200, 1'b0, 3'd0, '0);
        cpu_access(1'b0, 32'h208, '0, s);

        // Reset during refill aborts it and drops every resident line
        push_txn(1'b0, 32'h600, 1'b0, 3'd0, '0);
        @(negedge clk);
        bus.p1_addr_i    = 32'h600;
        bus.p1_MemRead_i = 1'b1;
        for (i = 0; i < BUDGET && !(bus.mem_enable_o && !bus.mem_write_o); i++) @(negedge clk);
        chk("t6_refill_seen", 32'(bus.mem_enable_o), 32'd1);
        @(negedge clk);
        rst              = 1'b1;
        bus.p1_MemRead_i = 1'b0;
        @(negedge clk);
        #1;
        chk("t6_enable", 32'(bus.mem_enable_o), 32'd0);
        chk("t6_write", 32'(bus.mem_write_o), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        refm.delete(32'h44);
        push_txn(1'b0, 32'h40, 1'b0, 3'd0, '0);
        cpu_access(1'b0, 32'h40, '0, s);
        chk("t6_cold_stalls", 32'(s), 32'(3 + MEM_DELAY));
        cpu_access(1'b0, 32'h44, '0, s);
        chk("t6_hit_stalls", 32'(s), 32'd0);

        repeat (4) @(negedge clk);
        chk("txn_drained", 32'(exp_txn.size()), 32'd0);
        chk("load_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
